echo_meas: RTL and testbench

- Downstream companion of the trigger generator in the ultrasonic ranging path.
- Armed by the trigger stage's completion pulse. Watches the sensor's asynchronous echo line and measures the echo high time in prescaled ticks.
- Presents a registered width result with a one-cycle valid strobe and an error code for the range/distance logic that follows.

---
 rtl/echo_meas_if.sv | 21 ++
 rtl/echo_meas.sv | 171 +++++++++++++++++
 tb/tb_echo_meas.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/echo_meas_if.sv
// echo_meas bus: arm/echo inputs and the registered result bundle.
interface echo_meas_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             echo;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] width;
    logic [1:0]       err;

    modport master (
        output start, echo,
        input  busy, valid, width, err
    );

    modport slave (
        input  start, echo,
        output busy, valid, width, err
    );
endinterface

// File: rtl/echo_meas.sv
// Ultrasonic echo high-time meter in prescaled ticks.
// Optional ECHO_GLITCH_FILTER_EN: 3-cycle stability filter on echo.
module echo_meas #(
    parameter int WIDTH     = 16,
    parameter int PRESCALE  = 50,
    parameter int MAX_WAIT  = 1000,
    parameter int MAX_TICKS = 60000
) (
    input  logic        clk,
    input  logic        rst,
    echo_meas_if.slave  bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] WAIT_T  = WIDTH'(MAX_WAIT);
    localparam logic [WIDTH-1:0] SAT_T   = WIDTH'(MAX_TICKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_MEAS,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_n;
    logic [PW-1:0]    r_presc;
    logic [PW-1:0]    w_presc_n;
    logic [WIDTH-1:0] r_tick;
    logic [WIDTH-1:0] w_tick_n;
    logic [WIDTH-1:0] r_width;
    logic [WIDTH-1:0] w_width_n;
    logic [1:0]       r_err;
    logic [1:0]       w_err_n;

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic w_echo_f;
    logic w_rise;
    logic w_fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= bus.echo;
            r_sync2 <= r_sync1;
            r_prev  <= w_echo_f;
        end
    end

`ifdef ECHO_GLITCH_FILTER_EN
    logic r_h1;
    logic r_h2;
    logic r_filt;
    logic w_all_hi;
    logic w_all_lo;

    // Level moves only once three consecutive samples agree.
    assign w_all_hi = r_sync2 & r_h1 & r_h2;
    assign w_all_lo = ~(r_sync2 | r_h1 | r_h2);

    always_comb begin
        w_echo_f = r_filt;
        if (w_all_hi) begin
            w_echo_f = 1'b1;
        end else if (w_all_lo) begin
            w_echo_f = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_h1   <= 1'b0;
            r_h2   <= 1'b0;
            r_filt <= 1'b0;
        end else begin
            r_h1   <= r_sync2;
            r_h2   <= r_h1;
            r_filt <= w_echo_f;
        end
    end
`else
    assign w_echo_f = r_sync2;
`endif

    assign w_rise = w_echo_f & ~r_prev;
    assign w_fall = ~w_echo_f & r_prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_tick  <= '0;
            r_width <= '0;
            r_err   <= 2'b00;
        end else begin
            r_state <= w_state_n;
            r_presc <= w_presc_n;
            r_tick  <= w_tick_n;
            r_width <= w_width_n;
            r_err   <= w_err_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_presc_n = r_presc;
        w_tick_n  = r_tick;
        w_width_n = r_width;
        w_err_n   = r_err;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_n = S_WAIT;
                    w_presc_n = '0;
                    w_tick_n  = '0;
                end
            end
            S_WAIT: begin
                if (w_rise) begin
                    // The edge cycle is the first high cycle.
                    w_state_n = S_MEAS;
                    w_presc_n = PW'(1);
                    w_tick_n  = '0;
                end else if (r_tick == WAIT_T) begin
                    w_state_n = S_DONE;
                    w_width_n = '0;
                    w_err_n   = 2'b01;
                end else if (r_presc == PS_LAST) begin
                    w_presc_n = '0;
                    w_tick_n  = r_tick + WIDTH'(1);
                end else begin
                    w_presc_n = r_presc + PW'(1);
                end
            end
            S_MEAS: begin
                if (w_fall) begin
                    w_state_n = S_DONE;
                    w_width_n = r_tick;
                    w_err_n   = 2'b00;
                end else if (r_tick == SAT_T) begin
                    w_state_n = S_DONE;
                    w_width_n = SAT_T;
                    w_err_n   = 2'b10;
                end else if (w_echo_f) begin
                    if (r_presc == PS_LAST) begin
                        w_presc_n = '0;
                        w_tick_n  = r_tick + WIDTH'(1);
                    end else begin
                        w_presc_n = r_presc + PW'(1);
                    end
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign bus.busy  = (r_state != S_IDLE);
    assign bus.valid = (r_state == S_DONE);
    assign bus.width = r_width;
    assign bus.err   = r_err;
endmodule

// File: tb/tb_echo_meas.sv
// Randomised self-checking bench for echo_meas against a pulse-length model.
// Expected results follow from pin-level high time and the tick rules.
module tb_echo_meas;
    localparam int PS  = 10;
    localparam int MW  = 100;
    localparam int MT  = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int n_val = 0;

    echo_meas_if #(.WIDTH(16)) bus ();

    echo_meas #(
        .WIDTH    (16),
        .PRESCALE (PS),
        .MAX_WAIT (MW),
        .MAX_TICKS(MT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.valid) n_val <= n_val + 1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(string tag, int bound, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.valid && cyc < bound);
        check(tag, {31'd0, bus.valid}, 32'd1);
    endtask

    // Reference: N pin-high cycles give floor(N/PS) ticks; beyond
    // MT*PS cycles the meter saturates before the fall arrives.
    function automatic logic [17:0] model(int h);
        if (h > MT * PS) return {2'b10, 16'(MT)};
        return {2'b00, 16'(h / PS)};
    endfunction

    task automatic run_meas(int d, int h);
        int         base;
        int         cyc;
        bit         got;
        logic [15:0] w;
        logic [1:0]  e;
        logic [17:0] exp_r;
        base = n_val;
        got  = 1'b0;
        w    = '0;
        e    = '0;
        pulse_start();
        check("busy_arm", {31'd0, bus.busy}, 32'd1);
        tick(d);
        bus.echo = 1'b1;
        for (int i = 0; i < h; i++) begin
            @(negedge clk);
            bus.start = (i < 40) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (bus.valid && !got) begin
                got = 1'b1;
                w   = bus.width;
                e   = bus.err;
            end
        end
        bus.echo  = 1'b0;
        bus.start = 1'b0;
        if (!got) begin
            wait_valid("rnd_timeout", 12, cyc);
            w = bus.width;
            e = bus.err;
        end
        exp_r = model(h);
        check("rnd_width", 32'(w), 32'(exp_r[15:0]));
        check("rnd_err", 32'(e), 32'(exp_r[17:16]));
        @(negedge clk);
        check("rnd_idle", {31'd0, bus.busy}, 32'd0);
        tick(3);
        check("rnd_one_valid", 32'(n_val - base), 32'd1);
    endtask

    initial begin
        int cyc;
        int base;
        int d;
        int h;
        bus.start = 1'b0;
        bus.echo  = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.echo = ~bus.echo;
            check("rst_hold",
                  {12'd0, bus.busy, bus.valid, bus.width, bus.err},
                  32'd0);
        end
        bus.echo = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick(4);

        pulse_start();
        check("basic_busy", {31'd0, bus.busy}, 32'd1);
        tick(20);
        bus.echo = 1'b1;
        tick(100);
        bus.echo = 1'b0;
        wait_valid("basic_timeout", 20, cyc);
`ifdef ECHO_GLITCH_FILTER_EN
        check("basic_lat", 32'(cyc >= 4 && cyc <= 6), 32'd1);
`else
        check("basic_lat", 32'(cyc >= 2 && cyc <= 4), 32'd1);
`endif
        check("basic_width", 32'(bus.width), 32'd10);
        check("basic_err", 32'(bus.err), 32'd0);
        bus.start = 1'b1;
        @(negedge clk);
        check("done_start_ign", {30'd0, bus.busy, bus.valid}, 32'd0);
        @(negedge clk);
        check("idle_start_acc", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        wait_valid("noecho_timeout", 1100, cyc);
        check("noecho_lat", 32'(cyc >= 998 && cyc <= 1004), 32'd1);
        check("noecho_width", 32'(bus.width), 32'd0);
        check("noecho_err", 32'(bus.err), 32'd1);
        tick(3);

        pulse_start();
        tick(5);
        bus.echo = 1'b1;
        wait_valid("ovf_timeout", 2100, cyc);
        check("ovf_lat", 32'(cyc >= 1998 && cyc <= 2012), 32'd1);
        check("ovf_width", 32'(bus.width), 32'(MT));
        check("ovf_err", 32'(bus.err), 32'd2);
        tick(20);
        check("ovf_idle_hi", {31'd0, bus.busy}, 32'd0);
        bus.echo = 1'b0;
        tick(5);

        base = n_val;
        bus.echo = 1'b1;
        tick(5);
        pulse_start();
        tick(20);
        check("prehigh_wait", {31'd0, bus.busy}, 32'd1);
        check("prehigh_noval", 32'(n_val - base), 32'd0);
        bus.echo = 1'b0;
        tick(10);
        bus.echo = 1'b1;
        tick(50);
        bus.echo = 1'b0;
        wait_valid("prehigh_timeout", 20, cyc);
        check("prehigh_width", 32'(bus.width), 32'd5);
        check("prehigh_err", 32'(bus.err), 32'd0);
        tick(3);

        base = n_val;
        pulse_start();
        tick(10);
        bus.echo = 1'b1;
        tick(50);
        bus.echo = 1'b0;
        tick(2);
        bus.echo = 1'b1;
        tick(48);
        bus.echo = 1'b0;
        tick(15);
        check("drop_one_valid", 32'(n_val - base), 32'd1);
`ifdef ECHO_GLITCH_FILTER_EN
        check("drop_width", 32'(bus.width), 32'd10);
`else
        check("drop_width", 32'(bus.width), 32'd5);
`endif
        check("drop_err", 32'(bus.err), 32'd0);

        pulse_start();
        tick(5);
        bus.echo = 1'b1;
        tick(300);
        base = n_val;
        rst = 1'b0;
        #1;
        check("rst_mid",
              {12'd0, bus.busy, bus.valid, bus.width, bus.err}, 32'd0);
        tick(3);
        check("rst_mid_hold",
              {12'd0, bus.busy, bus.valid, bus.width, bus.err}, 32'd0);
        bus.echo = 1'b0;
        rst = 1'b1;
        tick(5);
        check("rst_mid_noval", 32'(n_val - base), 32'd0);
        check("rst_mid_idle", {31'd0, bus.busy}, 32'd0);

        for (int k = 0; k < 12; k++) begin
            d = $urandom_range(3, 600);
            h = $urandom_range(5, 2300);
            if (h >= 1990 && h <= 2010) h = 2020;
            run_meas(d, h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
